// File: rtl/seven_seg_scanner_pkg.sv
// Shared display constants and parameter checks for the seven-segment scanner.
// All segment and anode patterns are active-low.
package seven_seg_scanner_pkg;

    localparam int MAX_DIGITS = 8;
    localparam int MIN_DIGITS = 2;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [MAX_DIGITS-1:0] AN_OFF = '1;

    function automatic bit num_digits_ok(input int n);
        return (n >= MIN_DIGITS) && (n <= MAX_DIGITS);
    endfunction

endpackage

// File: rtl/seven_seg_scanner_decoder.sv
// Nibble to active-low seven-segment glyph, bit order {g,f,e,d,c,b,a}.
// Digits 0..9 are decimal, A..F use the usual A b C d E F shapes.
module seven_seg_decoder
    import seven_seg_scanner_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        case (nibble_i)
            4'h0: seg_o = 7'h40;
            4'h1: seg_o = 7'h79;
            4'h2: seg_o = 7'h24;
            4'h3: seg_o = 7'h30;
            4'h4: seg_o = 7'h19;
            4'h5: seg_o = 7'h12;
            4'h6: seg_o = 7'h02;
            4'h7: seg_o = 7'h78;
            4'h8: seg_o = 7'h00;
            4'h9: seg_o = 7'h10;
            4'hA: seg_o = 7'h08;
            4'hB: seg_o = 7'h03;
            4'hC: seg_o = 7'h46;
            4'hD: seg_o = 7'h21;
            4'hE: seg_o = 7'h06;
            4'hF: seg_o = 7'h0E;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seven_seg_scanner.sv
// Multiplexed seven-segment scanner with PWM brightness, frame snapshot
// and leading-zero blanking; all display outputs are registered.
module seven_seg_scanner
    import seven_seg_scanner_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int PRESCALE_LOG2 = 16,
    parameter int BRIGHT_W      = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    blank_lz,
    input  logic [BRIGHT_W-1:0]     brightness,
    input  logic                    enable,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_tick
);

    localparam int SEL_W = $clog2(NUM_DIGITS);
    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] AN_DARK = AN_OFF[NUM_DIGITS-1:0];

    generate
        if (!num_digits_ok(NUM_DIGITS)) begin : g_bad_digits
            $error("seven_seg_scanner: NUM_DIGITS must be 2..8");
        end
        if (BRIGHT_W > PRESCALE_LOG2) begin : g_bad_bright
            $error("seven_seg_scanner: BRIGHT_W exceeds PRESCALE_LOG2");
        end
    endgenerate

    logic [PRESCALE_LOG2-1:0] cnt_q, cnt_d;
    logic [SEL_W-1:0]         sel_q, sel_d;
    logic [4*NUM_DIGITS-1:0]  snap_dig_q, snap_dig_d;
    logic [NUM_DIGITS-1:0]    snap_dp_q, snap_dp_d;
    logic                     snap_blz_q, snap_blz_d;
    logic [6:0]               seg_q, seg_d;
    logic                     dp_q, dp_d;
    logic [NUM_DIGITS-1:0]    an_q, an_d;
    logic                     tick_q, tick_d;

    logic                     wrap;
    logic                     last;
    logic                     lit;
    logic [NUM_DIGITS-1:0]    blank;
    logic [3:0]               nib;
    logic                     nib_blank;
    logic                     nib_dp;
    logic [6:0]               dec_seg;

    assign wrap = enable && (cnt_q == '1);
    assign last = (sel_q == SEL_LAST);

    // Slot 0 is dark so the anode switch never overlaps a stale segment.
    assign lit = enable && (cnt_q != '0) &&
                 (cnt_q[PRESCALE_LOG2-1 -: BRIGHT_W] <= brightness);

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_lz
        if (i == 0) begin : g_units
            assign blank[i] = 1'b0;
        end else begin : g_upper
            assign blank[i] = snap_blz_q &&
                (snap_dig_q[4*NUM_DIGITS-1:4*i] == '0);
        end
    end

    always_comb begin
        nib       = 4'h0;
        nib_blank = 1'b0;
        nib_dp    = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (sel_q == SEL_W'(i)) begin
                nib       = snap_dig_q[4*i +: 4];
                nib_blank = blank[i];
                nib_dp    = snap_dp_q[i];
            end
        end
    end

    seven_seg_decoder u_dec (
        .nibble_i (nib),
        .seg_o    (dec_seg)
    );

    always_comb begin
        cnt_d      = cnt_q;
        sel_d      = sel_q;
        snap_dig_d = snap_dig_q;
        snap_dp_d  = snap_dp_q;
        snap_blz_d = snap_blz_q;
        tick_d     = 1'b0;
        if (enable) begin
            cnt_d = cnt_q + 1'b1;
        end
        if (wrap) begin
            sel_d = last ? '0 : sel_q + 1'b1;
        end
        if (wrap && last) begin
            snap_dig_d = digits;
            snap_dp_d  = dp_in;
            snap_blz_d = blank_lz;
            tick_d     = 1'b1;
        end
    end

    always_comb begin
        seg_d = SEG_BLANK;
        dp_d  = 1'b1;
        an_d  = AN_DARK;
        if (lit) begin
            seg_d = nib_blank ? SEG_BLANK : dec_seg;
            dp_d  = ~nib_dp;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                an_d[i] = (sel_q != SEL_W'(i));
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            sel_q      <= '0;
            snap_dig_q <= '0;
            snap_dp_q  <= '0;
            snap_blz_q <= 1'b0;
            seg_q      <= SEG_BLANK;
            dp_q       <= 1'b1;
            an_q       <= AN_DARK;
            tick_q     <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            sel_q      <= sel_d;
            snap_dig_q <= snap_dig_d;
            snap_dp_q  <= snap_dp_d;
            snap_blz_q <= snap_blz_d;
            seg_q      <= seg_d;
            dp_q       <= dp_d;
            an_q       <= an_d;
            tick_q     <= tick_d;
        end
    end

    assign seg        = seg_q;
    assign dp         = dp_q;
    assign an         = an_q;
    assign frame_tick = tick_q;

endmodule

// File: doc/seven_seg_scanner.md
SEVEN_SEG_SCANNER -- requirements
Module: seven_seg_scanner

Interface
REQ-001 Parameter NUM_DIGITS, default 4, number of multiplexed digits; legal range 2..8.
REQ-002 Parameter PRESCALE_LOG2, default 16, log2 of clk cycles per digit slot.
REQ-003 Parameter BRIGHT_W, default 3, brightness code width; SHALL be less than or equal to PRESCALE_LOG2.
REQ-004 clk  in  1  sole clock; all state changes on its rising edge.
REQ-005 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 digits  in  4*NUM_DIGITS  nibble i (bits 4i+3:4i) is digit i; digit 0 is rightmost.
REQ-007 dp_in  in  NUM_DIGITS  decimal-point request per digit, 1 = lit.
REQ-008 blank_lz  in  1  1 = leading-zero suppression on.
REQ-009 brightness  in  BRIGHT_W  duty code; 0 = dimmest, all-ones = full.
REQ-010 enable  in  1  0 = display dark, counters frozen.
REQ-011 seg  out  7  segment lines, active-low, registered.
REQ-012 dp  out  1  decimal point, active-low, registered.
REQ-013 an  out  NUM_DIGITS  digit anodes, active-low, one-hot-low when lit, registered.
REQ-014 frame_tick  out  1  one-cycle pulse when a new input snapshot is taken.

Function
REQ-015 A PRESCALE_LOG2-bit counter cnt SHALL increment every cycle while enable=1, wrapping from 2^PRESCALE_LOG2-1 to 0.
REQ-016 A slot index sel (0..NUM_DIGITS-1) SHALL advance on the cnt wrap cycle and wrap from NUM_DIGITS-1 to 0; it SHALL never take values of NUM_DIGITS or above.
REQ-017 On the wrap cycle where sel=NUM_DIGITS-1, the block SHALL capture digits, dp_in and blank_lz into a snapshot register and pulse frame_tick high for exactly that following cycle.
REQ-018 Displayed values SHALL come only from the snapshot; input changes mid-frame SHALL NOT appear until the next frame_tick.
REQ-019 The digit is lit when enable=1, cnt is not 0, and cnt[PRESCALE_LOG2-1 -: BRIGHT_W] is less than or equal to brightness.
REQ-020 cnt=0 SHALL always be dark, providing a one-cycle anti-ghosting gap.
REQ-021 When the digit is lit, an SHALL have only bit sel low and seg SHALL be the decode of snapshot nibble sel.
REQ-022 Nibbles 0..9 SHALL decode as decimal and A..F as hex glyphs.
REQ-023 When lit, dp SHALL equal NOT snapshot dp_in[sel].
REQ-024 When the slot is dark, an SHALL be all ones, and seg and dp SHALL be all ones.
REQ-025 With snapshot blank_lz=1, digit i (i>0) SHALL be blanked when nibbles NUM_DIGITS-1 down to i are all zero.
REQ-026 For a blanked digit, seg SHALL be 7'h7F while the anode still follows REQ-019, and dp SHALL still follow dp_in.
REQ-027 Digit 0 SHALL never be blanked.
REQ-028 seg, dp and an SHALL reflect the cnt, sel and snapshot values of the previous cycle (one-cycle registered latency).
REQ-029 When enable falls, an, seg and dp SHALL go all-ones next cycle, cnt and sel SHALL hold, and no frame_tick SHALL occur.
REQ-030 When enable rises again, scanning SHALL resume from the held cnt and sel.
REQ-031 A brightness change SHALL take effect on the next cycle, without waiting for a frame boundary.

Reset
REQ-032 While rst_n=0, the block SHALL hold cnt=0, sel=0, snapshot all zeros, an all ones, seg=7'h7F, dp=1 and frame_tick=0, applied asynchronously.
REQ-033 After release, scanning SHALL start at digit 0 with cnt=0; the first frame SHALL display the zero snapshot.
REQ-034 Reset asserted mid-slot SHALL force outputs dark immediately, without waiting for a clk edge.

Structure
REQ-035 The active-low blank pattern 7'h7F and the anode-off pattern SHALL live in the shared display package.
REQ-036 The NUM_DIGITS legal-range check SHALL live in the shared display package.
REQ-037 The existing seven_seg_decoder SHALL be instantiated once as the sole sub-module for nibble-to-segment decode.
REQ-038 Leading-zero detection SHALL be combinational logic on the snapshot only.

Verification (NUM_DIGITS=4, PRESCALE_LOG2=4, BRIGHT_W=2)
REQ-039 Scan scenario: digits=16'h1234, brightness=3, blank_lz=0, enable=1; after the first frame_tick, expect an=1110 with the seg glyph for "4" for 15 of every 16 cycles, followed by digits 3, 2, 1 in order, and frame_tick every 64 cycles.
REQ-040 Brightness scenario: brightness=0; expect an low only at cnt 1..3, i.e. 3 of every 16 cycles per slot.
REQ-041 Blanking scenario: blank_lz=1 with digits=16'h0005; expect seg=7'h7F on slots 3..1 and the glyph "5" on slot 0. With digits=16'h0000, expect only slot 0 to show "0". With digits=16'h0105, expect slot 3 blanked and slot 1 to show "0".
REQ-042 Snapshot scenario: change digits from 16'h1234 to 16'hABCD at slot 1; expect output unchanged until the next frame_tick, then "D" on slot 0.
REQ-043 Enable scenario: deassert enable at cnt=7 of slot 2 for 20 cycles; expect an=1111 from the next cycle and no frame_tick, then resume at slot 2, cnt=7.
REQ-044 Reset scenario: assert rst_n=0 mid-slot between clk edges; expect an=1111 and seg=7'h7F immediately; after release, expect the scan to restart at slot 0 showing zeros.
